// File: rtl/pux_pkg.sv
// Shared definitions for the PUX output stream: FSM encoding, status codes
// and the bit layout of a result FIFO entry.
`timescale 1ns/1ps
package pux_pkg;

    typedef enum logic {
        STREAM = 1'b0,
        STATUS = 1'b1
    } pux_state_e;

    localparam logic [1:0] PUX_ST_OK  = 2'b00;
    localparam logic [1:0] PUX_ST_ERR = 2'b01;
    localparam logic [1:0] PUX_ST_OVF = 2'b10;

    // FIFO entry layout, LSB first: {status, last, data}
    localparam int ENT_DATA_LSB = 0;

    function automatic int ent_last_bit(input int dataw);
        return dataw;
    endfunction

    function automatic int ent_status_lsb(input int dataw);
        return dataw + 1;
    endfunction

endpackage

// File: rtl/pux_so_if.sv
// Bus bundle for pux_so: core result write port plus the result and status
// AXI-Stream channels. The slave modport is the pux_so side.
`timescale 1ns/1ps
interface pux_so_if #(
    parameter int DATAW   = 16,
    parameter int STATUSW = 2
);
    logic [DATAW-1:0]   res_data;
    logic               res_last;
    logic [STATUSW-1:0] res_status;
    logic               res_valid;
    logic               res_ready;

    logic [DATAW-1:0]   axis_result_data;
    logic               axis_result_last;
    logic               axis_result_valid;
    logic               axis_result_ready;

    logic [STATUSW-1:0] axis_status_data;
    logic               axis_status_valid;
    logic               axis_status_ready;

    modport master (
        output res_data, res_last, res_status, res_valid,
        output axis_result_ready, axis_status_ready,
        input  res_ready,
        input  axis_result_data, axis_result_last, axis_result_valid,
        input  axis_status_data, axis_status_valid
    );

    modport slave (
        input  res_data, res_last, res_status, res_valid,
        input  axis_result_ready, axis_status_ready,
        output res_ready,
        output axis_result_data, axis_result_last, axis_result_valid,
        output axis_status_data, axis_status_valid
    );

endinterface

// File: rtl/pux_sync_fifo.sv
// Generic first-word-fall-through FIFO: the head entry is always visible on
// rd_data; pointers carry one extra wrap bit to tell full from empty.
`timescale 1ns/1ps
module pux_sync_fifo #(
    parameter int WIDTH = 19,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_reg;
    logic [AW:0]      rptr_reg;
    logic             wr_fire;
    logic             rd_fire;

    assign empty = (wptr_reg == rptr_reg);
    assign full  = (wptr_reg[AW] != rptr_reg[AW]) &&
                   (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign level = wptr_reg - rptr_reg;

    // A full FIFO refuses writes even when a read frees a slot this cycle.
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (srst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (wr_fire) wptr_reg <= wptr_reg + 1'b1;
            if (rd_fire) rptr_reg <= rptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wptr_reg[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rptr_reg[AW-1:0]];

endmodule

// File: rtl/pux_so.sv
// PUX result transmitter: buffers core results in a FWFT FIFO, streams them
// out and emits one status word after every packet before the next starts.
`timescale 1ns/1ps
module pux_so
    import pux_pkg::*;
#(
    parameter int DATAW    = 16,
    parameter int STATUSW  = 2,
    parameter int RESFIFOW = 3
) (
    input  logic              axis_clk,
    input  logic              axis_rst,
    pux_so_if.slave           so,
    output logic [RESFIFOW:0] fifo_level,
    output logic              pkt_done
);
    localparam int ENTW     = DATAW + STATUSW + 1;
    localparam int LAST_BIT = ent_last_bit(DATAW);
    localparam int ST_LSB   = ent_status_lsb(DATAW);

    pux_state_e         state_reg;
    logic [STATUSW-1:0] status_data_reg;
    logic               status_valid_reg;
    logic               pkt_done_reg;

    logic [ENTW-1:0]    wr_entry;
    logic [ENTW-1:0]    head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               wr_en;
    logic               rd_en;
    logic               head_last;
    logic [STATUSW-1:0] head_status;

    assign wr_entry    = {so.res_status, so.res_last, so.res_data};
    assign head_last   = head_entry[LAST_BIT];
    assign head_status = head_entry[ST_LSB +: STATUSW];

    // Handshake outputs are held low during reset regardless of FIFO state.
    assign so.res_ready         = !fifo_full && !axis_rst;
    assign so.axis_result_valid = (state_reg == STREAM) && !fifo_empty && !axis_rst;
    assign so.axis_result_data  = head_entry[ENT_DATA_LSB +: DATAW];
    assign so.axis_result_last  = head_last;
    assign so.axis_status_data  = status_data_reg;
    assign so.axis_status_valid = status_valid_reg;
    assign pkt_done             = pkt_done_reg;

    assign wr_en = so.res_valid && so.res_ready;
    assign rd_en = so.axis_result_valid && so.axis_result_ready;

    pux_sync_fifo #(
        .WIDTH (ENTW),
        .AW    (RESFIFOW)
    ) u_fifo (
        .clk     (axis_clk),
        .srst    (axis_rst),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_reg        <= STREAM;
            status_data_reg  <= '0;
            status_valid_reg <= 1'b0;
            pkt_done_reg     <= 1'b0;
        end else begin
            pkt_done_reg <= 1'b0;
            unique case (state_reg)
                STREAM: begin
                    if (rd_en && head_last) begin
                        status_data_reg  <= head_status;
                        status_valid_reg <= 1'b1;
                        state_reg        <= STATUS;
                    end
                end
                STATUS: begin
                    if (so.axis_status_ready) begin
                        status_valid_reg <= 1'b0;
                        pkt_done_reg     <= 1'b1;
                        state_reg        <= STREAM;
                    end
                end
                default: state_reg <= STREAM;
            endcase
        end
    end

endmodule

// File: doc/pux_so.md
Name: pux_so

Overview:
- Output stream interface of the PUX arithmetic unit; the transmit counterpart to the operand/opcode input interface.
- Buffers result words from the PUX core in a FIFO and emits them on the AXI-Stream result channel with a last marker.
- After each result packet, emits one status word on the status stream before the next packet may start.
- Sits between the PUX core result port and the external result/status stream sinks.

Parameters:
- DATAW, 16, result word width.
- STATUSW, 2, status word width.
- RESFIFOW, 3, FIFO address width; depth is 2^RESFIFOW entries and pointers are RESFIFOW+1 bits.

Ports:
- axis_clk  in  1  module clock; all logic on the rising edge.
- axis_rst  in  1  synchronous, active-high reset.
- res_data  in  DATAW  result word from the core.
- res_last  in  1  marks the final word of a result packet.
- res_status  in  STATUSW  packet status; sampled only when res_last=1.
- res_valid  in  1  core write request.
- res_ready  out  1  FIFO can accept a word.
- axis_result_data  out  DATAW  result stream data.
- axis_result_last  out  1  result stream end-of-packet marker.
- axis_result_valid  out  1  result stream valid.
- axis_result_ready  in  1  result stream sink ready.
- axis_status_data  out  STATUSW  packet status.
- axis_status_valid  out  1  status valid.
- axis_status_ready  in  1  status sink ready.
- fifo_level  out  RESFIFOW+1  current FIFO occupancy, 0..2^RESFIFOW.
- pkt_done  out  1  one-cycle pulse when a packet's status handshake completes.

Behaviour:
- Clock and reset: single clock axis_clk; reset is synchronous and active-high on axis_rst.
- Reset actions: write and read pointers go to 0, the FSM goes to STREAM, and the status register and pkt_done go to 0.
- Reset gating: res_ready and axis_result_valid are forced to 0 combinationally while axis_rst=1. FIFO contents are discarded.
- Reset mid-packet: the partial packet is dropped and no status word is emitted for it.
- FIFO entry format: {status, last, data}, DATAW+STATUSW+1 bits wide. The FIFO is first-word-fall-through: the head entry drives axis_result_data and axis_result_last directly.
- Empty flag: full pointers are equal.
- Full flag: pointer MSBs differ and the lower RESFIFOW bits are equal.
- fifo_level = wptr - rptr, modulo 2^(RESFIFOW+1).
- Write side:
  - res_ready = !full.
  - A write occurs when res_valid & res_ready; wptr increments and wraps naturally.
  - A write is blocked when full even if a read happens in the same cycle (no full-bypass).
- Write-to-output latency: a word written in cycle N is visible on axis_result_valid in cycle N+1 at the earliest.
- FSM states: STREAM and STATUS.
- STREAM state:
  - axis_result_valid = !empty; axis_status_valid = 0.
  - A read occurs on axis_result_valid & axis_result_ready; rptr increments.
  - If the word read has last=1, its status field is latched into axis_status_data, axis_status_valid is set to 1 at the next edge, and the FSM moves to STATUS.
- STATUS state:
  - axis_result_valid = 0, so the result stream is stalled even if the FIFO is non-empty.
  - Writes into the FIFO continue.
  - On axis_status_ready=1: axis_status_valid clears, pkt_done pulses for one cycle, and the FSM returns to STREAM.
  - The next result word may then be presented in the following cycle.
- Simultaneous write and read in STREAM, not full: both pointers advance and the level is unchanged.
- Write on empty: no read in that cycle. Read on full: pointer frees a slot, and res_ready rises the next cycle.
- Data stability: axis_result_data/last must stay stable while valid is high and ready is low. axis_status_data must stay stable while axis_status_valid is high.
- A single-word packet (last=1 on the first word) is legal.
- Pointer arithmetic is unsigned and wraps at 2^(RESFIFOW+1).

Decomposition:
- Shared package pux_pkg holds:
  - FSM state encoding (STREAM=1'b0, STATUS=1'b1).
  - Status codes: PUX_ST_OK=2'b00, PUX_ST_ERR=2'b01, PUX_ST_OVF=2'b10.
  - FIFO entry field offsets.
- One natural sub-module: pux_sync_fifo, a generic FWFT FIFO with parameters WIDTH and AW, providing full, empty and level.
- pux_so instantiates pux_sync_fifo and adds the packet/status FSM.

Test Plan:
1. Reset behaviour: hold axis_rst=1 for 2 cycles with res_valid=1 -> res_ready=0, axis_result_valid=0, axis_status_valid=0, fifo_level=0.
2. Single packet: write 3 words 0x0001, 0x0002, 0x0003 (last on the third, status 2'b00), sink always ready -> the words appear in order starting the cycle after the first write, last=1 on 0x0003, then axis_status_data=00 and valid for one cycle, and pkt_done pulses once.
3. Fill to full: hold axis_result_ready=0 and write 9 words with default depth 8 -> res_ready drops after 8 writes, fifo_level=8, and the 9th word is not accepted until one read occurs.
4. Status backpressure: packet A (2 words, status 01) is followed immediately by packet B (1 word, status 00), with axis_status_ready=0 for 5 cycles -> no B word is presented while A's status is pending; B's status follows B's word.
5. Pointer wrap: stream 20 single-word packets with random ready/valid -> all 20 data and status values arrive in order and fifo_level returns to 0.
6. Reset mid-packet: assert axis_rst after 2 of 4 words are written -> no status is emitted, fifo_level=0, and the next packet is transmitted correctly.
